// File: rtl/arm_ctrl_seq_if.sv
// Sequencer <-> datapath/ROM bundle: fetch bus, interrupt input and control strobes.
// master = sequencer, slave = datapath + program ROM.
interface arm_ctrl_seq_if;
  logic [7:0]  PC;
  logic [7:0]  imem_addr;
  logic [15:0] instr;
  logic        CEENZ;
  logic        eint;
  logic [7:0]  Literal;
  logic [5:0]  Addr;
  logic [5:0]  calu;
  logic [1:0]  cpc;
  logic [1:0]  csrc;
  logic [2:0]  cmsrc;
  logic        wr_en;
  logic        cal;
  logic        ret;
  logic        pop;
  logic        push;
  logic        halted;
  logic        stk_err;
  logic        ill_op;

  modport master (
    input  PC, instr, CEENZ, eint,
    output imem_addr, Literal, Addr, calu, cpc, csrc, cmsrc,
           wr_en, cal, ret, pop, push, halted, stk_err, ill_op
  );

  modport slave (
    output PC, instr, CEENZ, eint,
    input  imem_addr, Literal, Addr, calu, cpc, csrc, cmsrc,
           wr_en, cal, ret, pop, push, halted, stk_err, ill_op
  );
endinterface

// File: rtl/arm_ctrl_seq.sv
// Instruction sequencer for the 8-bit ARM datapath: fetch/decode/exec FSM,
// interrupt arbitration and stack-depth guard. All strobes are registered.
//
//   state  | meaning
//   FETCH  | latch PC onto imem_addr, arbitrate pending interrupt
//   DECODE | ROM word valid; decode it into next-cycle strobes
//   EXEC   | strobes valid for the datapath
//   IRQ    | forced call to IRQ_VEC
//   HALT   | idle until reset
module arm_ctrl_seq #(
  parameter logic [7:0] IRQ_VEC     = 8'd170,
  parameter int         STACK_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  arm_ctrl_seq_if.master bus
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_IRQ, S_HALT} state_t;

  state_t         state;
  logic [3:0]     ir_op;
  logic [SPW-1:0] sp;
  logic           ie;
  logic           irq_pend;
  logic           eint_q;

  logic           eint_rise;
  logic           irq_go;
  logic [3:0]     op;
  logic [7:0]     d_lit;
  logic [5:0]     d_calu;
  logic [1:0]     d_cpc;
  logic [1:0]     d_csrc;
  logic [2:0]     d_cmsrc;
  logic           d_wr, d_cal, d_ret, d_pop, d_push;
  logic           d_ie, d_ill, d_err;
  logic [SPW-1:0] d_sp;

  assign eint_rise = bus.eint & ~eint_q;
  assign irq_go    = irq_pend & ie & (sp < SP_FULL);
  assign op        = bus.instr[15:12];

  always_comb begin
    d_lit   = '0;
    d_calu  = '0;
    d_cpc   = 2'd1;
    d_csrc  = 2'd0;
    d_cmsrc = 3'd0;
    d_wr    = 1'b0;
    d_cal   = 1'b0;
    d_ret   = 1'b0;
    d_pop   = 1'b0;
    d_push  = 1'b0;
    d_ie    = ie;
    d_ill   = 1'b0;
    d_err   = 1'b0;
    d_sp    = sp;
    case (op)
      4'h1: d_wr = 1'b1;
      4'h2: begin d_csrc = 2'd1; d_lit = bus.instr[7:0]; d_wr = 1'b1; end
      4'h3: begin d_csrc = 2'd2; d_cmsrc = bus.instr[2:0]; d_wr = 1'b1; end
      4'h4: begin d_csrc = 2'd3; d_calu = bus.instr[5:0]; d_wr = 1'b1; end
      4'h5: begin d_cpc = 2'd0; d_lit = bus.instr[7:0]; end
      4'h6: begin d_cpc = 2'd2; d_lit = bus.instr[7:0]; end
      4'h7: begin d_push = 1'b1; d_cmsrc = bus.instr[2:0]; end
      4'h8: begin d_pop = 1'b1; d_csrc = 2'd2; d_cmsrc = 3'd6; d_wr = 1'b1; end
      4'h9: begin d_cal = 1'b1; d_cpc = 2'd0; d_lit = bus.instr[7:0]; end
      4'hA: begin d_ret = 1'b1; d_cpc = 2'd0; end
      4'hB: begin d_ret = 1'b1; d_cpc = 2'd0; d_ie = 1'b1; end
      4'hC: d_ie = 1'b1;
      4'hD: d_ie = 1'b0;
      4'hE: d_ill = 1'b1;
      4'hF: d_cpc = 2'd3;
      default: ;
    endcase
    // A stack op that would over/underflow degrades to a plain increment.
    if (((d_push | d_cal) && sp == SP_FULL) || ((d_pop | d_ret) && sp == '0)) begin
      d_err  = 1'b1;
      d_push = 1'b0;
      d_cal  = 1'b0;
      d_pop  = 1'b0;
      d_ret  = 1'b0;
      d_wr   = 1'b0;
      d_cpc  = 2'd1;
    end else if (d_push | d_cal) begin
      d_sp = sp + 1'b1;
    end else if (d_pop | d_ret) begin
      d_sp = sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      ir_op         <= 4'h0;
      sp            <= '0;
      ie            <= 1'b0;
      irq_pend      <= 1'b0;
      eint_q        <= 1'b0;
      bus.imem_addr <= 8'h00;
      bus.Literal   <= 8'h00;
      bus.Addr      <= 6'h00;
      bus.calu      <= 6'h00;
      bus.cpc       <= 2'd3;
      bus.csrc      <= 2'd0;
      bus.cmsrc     <= 3'd0;
      bus.wr_en     <= 1'b0;
      bus.cal       <= 1'b0;
      bus.ret       <= 1'b0;
      bus.pop       <= 1'b0;
      bus.push      <= 1'b0;
      bus.halted    <= 1'b0;
      bus.stk_err   <= 1'b0;
      bus.ill_op    <= 1'b0;
    end else begin
      eint_q      <= bus.eint;
      bus.Literal <= 8'h00;
      bus.Addr    <= 6'h00;
      bus.calu    <= 6'h00;
      bus.cpc     <= 2'd3;
      bus.csrc    <= 2'd0;
      bus.cmsrc   <= 3'd0;
      bus.wr_en   <= 1'b0;
      bus.cal     <= 1'b0;
      bus.ret     <= 1'b0;
      bus.pop     <= 1'b0;
      bus.push    <= 1'b0;
      if (eint_rise) irq_pend <= 1'b1;
      case (state)
        S_FETCH: begin
          bus.imem_addr <= bus.PC;
          if (irq_go) begin
            state       <= S_IRQ;
            bus.cal     <= 1'b1;
            bus.cpc     <= 2'd0;
            bus.Literal <= IRQ_VEC;
            sp          <= sp + 1'b1;
            ie          <= 1'b0;
            // a fresh edge in this same cycle keeps the request pending
            if (!eint_rise) irq_pend <= 1'b0;
          end else begin
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          state       <= S_EXEC;
          ir_op       <= op;
          bus.Literal <= d_lit;
          bus.Addr    <= {2'b00, bus.instr[11:8]};
          bus.calu    <= d_calu;
          bus.cpc     <= d_cpc;
          bus.csrc    <= d_csrc;
          bus.cmsrc   <= d_cmsrc;
          bus.wr_en   <= d_wr;
          bus.cal     <= d_cal;
          bus.ret     <= d_ret;
          bus.pop     <= d_pop;
          bus.push    <= d_push;
          sp          <= d_sp;
          ie          <= d_ie;
          if (d_err) bus.stk_err <= 1'b1;
          if (d_ill) bus.ill_op  <= 1'b1;
        end
        S_EXEC: begin
          if (ir_op == 4'hF) begin
            state      <= S_HALT;
            bus.halted <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        S_IRQ:   state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_arm_ctrl_seq.sv
// Bench for arm_ctrl_seq: ROM + small datapath PC/stack model around the sequencer,
// expected strobe cycles queued up front and checked by an independent monitor.
module tb_arm_ctrl_seq;
  localparam logic [7:0] IRQ_VEC = 8'd170;

  typedef struct packed {
    logic [1:0] cpc;
    logic [7:0] lit;
    logic [5:0] addr;
    logic [5:0] calu;
    logic [1:0] csrc;
    logic [2:0] cmsrc;
    logic [4:0] str;   // {wr_en, cal, ret, pop, push}
    logic       stk;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [7:0]  ds[$];
  logic [15:0] rom [256];

  arm_ctrl_seq_if bus();

  arm_ctrl_seq #(.IRQ_VEC(IRQ_VEC), .STACK_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  always_comb bus.instr = rom[bus.imem_addr];

  // datapath stand-in: consumes cpc/cal/ret at the end of each strobe cycle
  always @(posedge clk) begin
    if (rst) begin
      bus.PC <= 8'h00;
      ds.delete();
    end else begin
      case (bus.cpc)
        2'd0: begin
          if (bus.ret) begin
            if (ds.size() > 0) bus.PC <= ds.pop_back();
          end else begin
            if (bus.cal) ds.push_back(bus.Literal == IRQ_VEC ? bus.PC : bus.PC + 8'd1);
            bus.PC <= bus.Literal;
          end
        end
        2'd1: bus.PC <= bus.PC + 8'd1;
        2'd2: bus.PC <= bus.PC + (bus.CEENZ ? 8'd2 : 8'd1);
        default: ;
      endcase
    end
  end

  function automatic exp_t e(input logic [1:0] cpc, input logic [7:0] lit,
                             input logic [5:0] addr, input logic [5:0] calu,
                             input logic [1:0] csrc, input logic [2:0] cmsrc,
                             input logic [4:0] str, input logic stk, input logic ill);
    exp_t r;
    r = '{cpc, lit, addr, calu, csrc, cmsrc, str, stk, ill};
    return r;
  endfunction

  function automatic exp_t act_now();
    exp_t r;
    r = '{bus.cpc, bus.Literal, bus.Addr, bus.calu, bus.csrc, bus.cmsrc,
          {bus.wr_en, bus.cal, bus.ret, bus.pop, bus.push}, bus.stk_err, bus.ill_op};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // monitor: every cycle with an active PC control is a strobe cycle
  always @(negedge clk) begin
    exp_t a, x;
    if (!rst && bus.cpc != 2'd3) begin
      a = act_now();
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe got=%h", a);
      end else begin
        x = sb.pop_front();
        if (a !== x) begin
          n_err++;
          $display("FAIL strobe_cycle got=%h want=%h", a, x);
        end
      end
    end
  end

  // interrupt pulses: one while LD R1 is in flight, one inside the first ISR
  initial begin
    int i;
    bus.eint = 1'b0;
    @(negedge clk);
    wait (!rst);
    for (i = 0; i < 2000 && bus.imem_addr != 8'h2E; i++) @(negedge clk);
    if (i == 2000) begin n_err++; $display("FAIL wait_ld_fetch got=timeout want=addr_2e"); end
    bus.eint = 1'b1;
    @(negedge clk);
    bus.eint = 1'b0;
    for (i = 0; i < 2000 && bus.imem_addr != IRQ_VEC; i++) @(negedge clk);
    if (i == 2000) begin n_err++; $display("FAIL wait_isr got=timeout want=addr_aa"); end
    bus.eint = 1'b1;
    @(negedge clk);
    bus.eint = 1'b0;
  end

  initial begin
    int i;
    bus.CEENZ = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    rom[8'h00] = 16'h222B; rom[8'h01] = 16'h50A2; rom[8'hA2] = 16'h603C; rom[8'hA3] = 16'h5020;
    rom[8'h20] = 16'h3705; rom[8'h21] = 16'h412A; rom[8'h22] = 16'h1300; rom[8'h23] = 16'h0000;
    rom[8'h24] = 16'hE000; rom[8'h25] = 16'h7001; rom[8'h26] = 16'h7002; rom[8'h27] = 16'h7003;
    rom[8'h28] = 16'h8400; rom[8'h29] = 16'h8500; rom[8'h2A] = 16'h8600; rom[8'h2B] = 16'h9040;
    rom[8'h40] = 16'hA000; rom[8'h2C] = 16'hA000; rom[8'h2D] = 16'hC000; rom[8'h2E] = 16'h2155;
    rom[8'hAA] = 16'h0000; rom[8'hAB] = 16'hB000; rom[8'h2F] = 16'hD000; rom[8'h30] = 16'hF000;

    sb.push_back(e(1, 8'h2B, 2, 0,    1, 0, 5'b10000, 0, 0)); // LD R2,43
    sb.push_back(e(0, 8'hA2, 0, 0,    0, 0, 5'b00000, 0, 0)); // JMP A2
    sb.push_back(e(2, 8'h3C, 0, 0,    0, 0, 5'b00000, 0, 0)); // SKNE 3C
    sb.push_back(e(0, 8'h20, 0, 0,    0, 0, 5'b00000, 0, 0)); // JMP 20
    sb.push_back(e(1, 8'h00, 7, 0,    2, 5, 5'b10000, 0, 0)); // MOV R7,R5
    sb.push_back(e(1, 8'h00, 1, 6'h2A, 3, 0, 5'b10000, 0, 0)); // ALU R1
    sb.push_back(e(1, 8'h00, 3, 0,    0, 0, 5'b10000, 0, 0)); // IN R3
    sb.push_back(e(1, 8'h00, 0, 0,    0, 0, 5'b00000, 0, 0)); // NOP
    sb.push_back(e(1, 8'h00, 0, 0,    0, 0, 5'b00000, 0, 1)); // reserved
    sb.push_back(e(1, 8'h00, 0, 0,    0, 1, 5'b00001, 0, 1)); // PUSH sp 0->1
    sb.push_back(e(1, 8'h00, 0, 0,    0, 2, 5'b00001, 0, 1)); // PUSH sp 1->2
    sb.push_back(e(1, 8'h00, 0, 0,    0, 3, 5'b00000, 1, 1)); // PUSH overflow
    sb.push_back(e(1, 8'h00, 4, 0,    2, 6, 5'b10010, 1, 1)); // POP R4
    sb.push_back(e(1, 8'h00, 5, 0,    2, 6, 5'b10010, 1, 1)); // POP R5
    sb.push_back(e(1, 8'h00, 6, 0,    2, 6, 5'b00000, 1, 1)); // POP underflow
    sb.push_back(e(0, 8'h40, 0, 0,    0, 0, 5'b01000, 1, 1)); // CALL 40
    sb.push_back(e(0, 8'h00, 0, 0,    0, 0, 5'b00100, 1, 1)); // RET
    sb.push_back(e(1, 8'h00, 0, 0,    0, 0, 5'b00000, 1, 1)); // RET underflow
    sb.push_back(e(1, 8'h00, 0, 0,    0, 0, 5'b00000, 1, 1)); // EI
    sb.push_back(e(1, 8'h55, 1, 0,    1, 0, 5'b10000, 1, 1)); // LD R1,55
    for (int k = 0; k < 2; k++) begin
      sb.push_back(e(0, IRQ_VEC, 0, 0, 0, 0, 5'b01000, 1, 1)); // IRQ entry
      sb.push_back(e(1, 8'h00, 0, 0,    0, 0, 5'b00000, 1, 1)); // ISR NOP
      sb.push_back(e(0, 8'h00, 0, 0,    0, 0, 5'b00100, 1, 1)); // RETI
    end
    sb.push_back(e(1, 8'h00, 0, 0,    0, 0, 5'b00000, 1, 1)); // DI

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpc", 32'(bus.cpc), 32'd3);
    chk("rst_strobes", 32'({bus.wr_en, bus.cal, bus.ret, bus.pop, bus.push}), 32'd0);
    chk("rst_flags", 32'({bus.halted, bus.stk_err, bus.ill_op}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_cpc", 32'(bus.cpc), 32'd3);
    @(negedge clk);
    chk("first_exec_cpc", 32'(bus.cpc), 32'd1);

    for (i = 0; i < 3000 && !bus.halted; i++) @(negedge clk);
    chk("halt_reached", 32'(bus.halted), 32'd1);
    chk("all_strobes_seen", 32'(sb.size()), 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("halt_idle", 32'({bus.halted, bus.cpc, bus.wr_en, bus.cal, bus.ret, bus.pop, bus.push}),
          32'b1_11_00000);
    end

    sb.push_back(e(1, 8'h2B, 2, 0, 1, 0, 5'b10000, 0, 0));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rerst_flags", 32'({bus.halted, bus.stk_err, bus.ill_op}), 32'd0);
    for (i = 0; i < 50 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("rerun_first_ld", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
